// File: rtl/medidor_desempenho_program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// medidor_desempenho_program_memory_arbiter
//
// Shares the single-port 8192 x 32 program memory between the instruction
// master (m0, read-only) and the data/loader master (m1, read/write). At most
// one access is granted per cycle. Read data comes back one cycle after the
// accept and is flagged to the master that issued the read. Two saturating
// counters record how many cycles each master was held off.
//
// Build option:
//   MEMARB_ROUND_ROBIN_EN  defined   -> contention alternates between masters
//                          undefined -> fixed priority, m0 always wins
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   m0_*                     instruction master (address/read in;
//                            waitrequest/readdata/readdatavalid out)
//   m1_*                     data master (address/read/write/writedata/
//                            byteenable in; waitrequest/readdata/
//                            readdatavalid out)
//   mem_*                    memory slave side (address/chipselect/write/
//                            writedata/byteenable out; readdata in)
//   cnt_clear                synchronous clear of both stall counters
//   m0_stall_cnt, m1_stall_cnt  saturating refused-request cycle counts
// ---------------------------------------------------------------------------
module medidor_desempenho_program_memory_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  m0_stall_cnt,
  output logic [CNT_W-1:0]  m1_stall_cnt
);

  logic m0_req;
  logic m1_req;
  logic contended;
  logic grant_m0;
  logic grant_m1;
  logic rd_issue;

  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Arbitration and memory command (combinational, accept cycle)
  always_comb begin
    m0_req    = m0_read;
    m1_req    = m1_read | m1_write;
    contended = m0_req & m1_req;
`ifdef MEMARB_ROUND_ROBIN_EN
    // Under contention m1 wins only if m0 had the previous contended grant.
    grant_m1  = m1_req & (~m0_req | ~last_grant);
`else
    grant_m1  = m1_req & ~m0_req;
`endif
    grant_m0  = m0_req & ~grant_m1;

    m0_waitrequest = m0_req & ~grant_m0;
    m1_waitrequest = m1_req & ~grant_m1;

    mem_chipselect = grant_m0 | grant_m1;
    mem_address    = grant_m1 ? m1_address : m0_address;
    // A simultaneous read+write from m1 is treated as a write.
    mem_write      = grant_m1 & m1_write;
    mem_writedata  = m1_writedata;
    mem_byteenable = grant_m0 ? {BE_W{1'b1}} : m1_byteenable;

    rd_issue = grant_m0 | (grant_m1 & ~m1_write);
  end

  // last_grant steers nothing in the fixed-priority build; keep it referenced.
  logic unused_last_grant;
  assign unused_last_grant = &{1'b0, last_grant};

  // Read-return stage: one cycle after the accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= 1'b1;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (contended) begin
        last_grant <= grant_m1;
      end
      rd_pend  <= rd_issue;
      rd_owner <= grant_m1;

      if (cnt_clear) begin
        m0_stall_cnt <= '0;
        m1_stall_cnt <= '0;
      end else begin
        if (m0_waitrequest) m0_stall_cnt <= sat_inc(m0_stall_cnt);
        if (m1_waitrequest) m1_stall_cnt <= sat_inc(m1_stall_cnt);
      end
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend &  rd_owner;

endmodule

// File: tb/tb_medidor_desempenho_program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for medidor_desempenho_program_memory_arbiter.
// Drives directed vectors on the falling edge, pushes the expected read
// responses into a queue, and a separate monitor pops and compares whenever
// either readdatavalid is seen. Counters use a 4-bit width so saturation is
// reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_medidor_desempenho_program_memory_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic              cnt_clear;
  logic [CNT_W-1:0]  m0_stall_cnt;
  logic [CNT_W-1:0]  m1_stall_cnt;

  medidor_desempenho_program_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .cnt_clear(cnt_clear),
    .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: byte-lane writes at the edge, registered one-cycle read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < BE_W; b++)
        if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    mem_readdata <= mem[mem_address];
  end

  typedef struct packed {
    logic              owner;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic             exp_lg;
  logic [CNT_W-1:0] exp_m0_cnt;
  logic [CNT_W-1:0] exp_m1_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat4(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (m0_readdatavalid && m1_readdatavalid) begin
        n_cmp++; n_bad++;
        $display("FAIL both_valid: got m0v=1 m1v=1, expected one-hot");
      end else if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got valid m1v=%0b, expected none", m1_readdatavalid);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_owner", {31'b0, m1_readdatavalid}, {31'b0, e.owner});
        check("resp_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0; cnt_clear = 1'b0;
  endtask

  // Both masters read in the same cycle; winner predicted from exp_lg.
  task automatic contend(input logic clr);
    logic m1_wins;
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h0010;
    m1_read = 1'b1; m1_write = 1'b0; m1_address = 13'h1FFF;
    cnt_clear = clr;
`ifdef MEMARB_ROUND_ROBIN_EN
    m1_wins = ~exp_lg;
`else
    m1_wins = 1'b0;
`endif
    exp_lg = m1_wins;
    #1;
    check("cont_m0_wait", {31'b0, m0_waitrequest}, {31'b0, m1_wins});
    check("cont_m1_wait", {31'b0, m1_waitrequest}, {31'b0, ~m1_wins});
    exp_q.push_back('{owner: m1_wins, data: m1_wins ? 32'hAAAA5678 : 32'hDEADBEEF});
    if (clr) begin
      exp_m0_cnt = '0; exp_m1_cnt = '0;
    end else if (m1_wins) exp_m0_cnt = sat4(exp_m0_cnt);
    else exp_m1_cnt = sat4(exp_m1_cnt);
  endtask

  int n_cont;
  int stalls;

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    mem[13'h0010] = 32'hDEADBEEF;
    mem[13'h1FFF] = 32'hAAAAAAAA;
    reset = 1'b1; cnt_clear = 1'b0;
    m0_address = '0; m0_read = 1'b0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
    m1_writedata = '0; m1_byteenable = '0;
    exp_lg = 1'b1; exp_m0_cnt = '0; exp_m1_cnt = '0;

    repeat (2) @(negedge clk);
    check("rst_m0v", {31'b0, m0_readdatavalid}, 32'h0);
    check("rst_m1v", {31'b0, m1_readdatavalid}, 32'h0);
    check("rst_m0cnt", {28'b0, m0_stall_cnt}, 32'h0);
    check("rst_m1cnt", {28'b0, m1_stall_cnt}, 32'h0);
    check("rst_cs", {31'b0, mem_chipselect}, 32'h0);
    reset = 1'b0;

    // Single m0 read
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h0010;
    #1;
    check("t1_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
    check("t1_cs", {31'b0, mem_chipselect}, 32'h1);
    check("t1_addr", {19'b0, mem_address}, 32'h0010);
    check("t1_we", {31'b0, mem_write}, 32'h0);
    check("t1_be", {28'b0, mem_byteenable}, 32'hF);
    exp_q.push_back('{owner: 1'b0, data: 32'hDEADBEEF});
    idle();
    idle();

    // m1 partial write then read-back
    @(negedge clk);
    m1_write = 1'b1; m1_address = 13'h1FFF;
    m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
    #1;
    check("t2_m1_wait_wr", {31'b0, m1_waitrequest}, 32'h0);
    check("t2_we", {31'b0, mem_write}, 32'h1);
    check("t2_be", {28'b0, mem_byteenable}, 32'h3);
    @(negedge clk);
    m1_write = 1'b0; m1_read = 1'b1;
    #1;
    check("t2_m1_wait_rd", {31'b0, m1_waitrequest}, 32'h0);
    exp_q.push_back('{owner: 1'b1, data: 32'hAAAA5678});
    idle();
    idle();

    // Sustained contention
`ifdef MEMARB_ROUND_ROBIN_EN
    n_cont = 6;
`else
    n_cont = 4;
`endif
    for (int i = 0; i < n_cont; i++) contend(1'b0);
    idle();
    #1;
`ifdef MEMARB_ROUND_ROBIN_EN
    check("t3_m0cnt", {28'b0, m0_stall_cnt}, 32'd3);
    check("t3_m1cnt", {28'b0, m1_stall_cnt}, 32'd3);
`else
    check("t3_m0cnt", {28'b0, m0_stall_cnt}, 32'd0);
    check("t3_m1cnt", {28'b0, m1_stall_cnt}, 32'd4);
`endif
    idle();

    // Reset in the cycle after an m0 read is accepted
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h0010;
    #1;
    check("t4_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1; m0_read = 1'b0;
    #1;
    check("t4_m0v", {31'b0, m0_readdatavalid}, 32'h0);
    check("t4_m1v", {31'b0, m1_readdatavalid}, 32'h0);
    check("t4_m0cnt", {28'b0, m0_stall_cnt}, 32'h0);
    check("t4_m1cnt", {28'b0, m1_stall_cnt}, 32'h0);
    check("t4_cs", {31'b0, mem_chipselect}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_lg = 1'b1; exp_m0_cnt = '0; exp_m1_cnt = '0;
    repeat (3) idle();

    // Saturation of m1_stall_cnt, then clear together with a stall
    for (int k = 0; k < 64 && exp_m1_cnt != {CNT_W{1'b1}}; k++) contend(1'b0);
    stalls = 0;
    for (int k = 0; k < 8 && stalls < 2; k++) begin
      contend(1'b0);
      if (exp_lg == 1'b0) stalls++;
    end
    idle();
    #1;
    check("t5_sat", {28'b0, m1_stall_cnt}, 32'hF);
    if (exp_lg == 1'b0) contend(1'b0);
    contend(1'b1);
    idle();
    #1;
    check("t5_clr_m1", {28'b0, m1_stall_cnt}, 32'h0);
    check("t5_clr_m0", {28'b0, m0_stall_cnt}, 32'h0);
    repeat (2) idle();

    check("drain", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/medidor_desempenho_program_memory_arbiter.md
# medidor_desempenho_program_memory_arbiter

Two-port arbiter sharing the single-port 8192 x 32 on-chip program memory between the processor instruction master (m0, read-only) and the data/loader master (m1, read/write). It sits between the two Avalon-MM masters and the memory's slave interface. It grants at most one access per cycle, routes the one-cycle-latency read data back to the owning master, and keeps saturating contention counters for the performance meter.

## Interface
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- CNT_W, 32, width of contention counters
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  instruction master word address
- m0_read  in  1  instruction read request
- m0_waitrequest  out  1  high = m0 request not accepted this cycle
- m0_readdata  out  DATA_W  read data to m0
- m0_readdatavalid  out  1  m0_readdata valid this cycle
- m1_address  in  ADDR_W  data master word address
- m1_read  in  1  data read request
- m1_write  in  1  data write request
- m1_writedata  in  DATA_W  write data
- m1_byteenable  in  BE_W  write byte lanes
- m1_waitrequest  out  1  high = m1 request not accepted this cycle
- m1_readdata  out  DATA_W  read data to m1
- m1_readdatavalid  out  1  m1_readdata valid this cycle
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_byteenable  out  BE_W  to memory byteenable
- mem_readdata  in  DATA_W  from memory readdata, valid one cycle after address
- cnt_clear  in  1  synchronous clear of both counters
- m0_stall_cnt  out  CNT_W  cycles m0 requested and was refused
- m1_stall_cnt  out  CNT_W  cycles m1 requested and was refused

## Operation
- Request: m0_req = m0_read; m1_req = m1_read | m1_write. If m1_read and m1_write are both high, the access is a write.
- Only one master is requesting: that master is granted.
- Both masters are requesting: the winner is chosen by the arbitration policy (see Configuration).
- Granted master: its waitrequest is low. Combinationally drive mem_address, mem_chipselect=1, and mem_write (write only for m1). Drive writedata/byteenable from m1. m0 grants force mem_byteenable=4'hF.
- No grant: mem_chipselect=0, mem_write=0. The losing master's waitrequest is high and it must hold its command.
- Registers:
  - last_grant: 0=m0, 1=m1. Updated only on a contended grant.
  - rd_pend: read issued last cycle.
  - rd_owner: which master issued that read.
- Read return: the cycle after a granted read, pulse the owner's readdatavalid for one cycle. Both readdata outputs carry mem_readdata directly. The non-owner's readdatavalid stays 0.
- Pipelined: back-to-back reads at one per cycle, with any mix of owners. Writes produce no response.
- Counters: each increments by 1 per cycle in which its master requests and waitrequest is high. They saturate at all-ones. cnt_clear has priority over increment.

## Timing
- Reset values: last_grant=1, rd_pend=0, rd_owner=0, both counters=0, both readdatavalid=0.
- Waitrequest is combinational from the requests. The accept cycle is the cycle with req=1 and waitrequest=0.
- Read latency: exactly 1 cycle from accept to readdatavalid.
- Write takes effect at the clk edge ending the accept cycle. A read by either master in the next cycle returns the new data.
- Reset asserted mid-read: the pending readdatavalid is suppressed, and no response is issued after reset deasserts.
- Counter wrap: at all-ones the counter holds its value; it never rolls to 0.
- Simultaneous cnt_clear and stall: the counter reads 0 on the next cycle.

## Configuration
- MEMARB_ROUND_ROBIN_EN defined: on contention, grant the master that is not last_grant, then set last_grant to the winner. Under sustained contention the grants alternate m0, m1, m0, …; the first contention after reset goes to m0.
- MEMARB_ROUND_ROBIN_EN undefined: fixed priority, m0 always wins contention. last_grant is still updated but is unused. m1 can starve.

## Test plan
- Single m0 read of addr 0x0010 (memory preloaded with 0xDEADBEEF): m0_waitrequest=0 in the accept cycle. One cycle later m0_readdatavalid=1 and m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- m1 write of 0x12345678 to 0x1FFF with byteenable 4'b0011, over a prior value of 0xAAAAAAAA; next cycle m1 read of the same address: returns 0xAAAA5678 one cycle after accept.
- Contention, macro defined: both masters hold reads for 6 cycles. Grants alternate m0, m1, m0, m1, m0, m1; each counter reads 3 afterwards.
- Contention, macro undefined: both masters request for 4 cycles. m0 is granted every cycle; m1_stall_cnt=4 and m0_stall_cnt=0.
- Reset pulse in the cycle after an m0 read is accepted: no readdatavalid is seen, and all outputs are at their reset values.
- Force m1_stall_cnt to all-ones, then stall 2 more cycles: value holds at all-ones. Assert cnt_clear together with a stall: next value is 0.
